// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: multicycle control FSM for an RV32 subset (R-type, addi, lb, sb, beq).
// Outputs are decoded from the state and forced to 0 asynchronously while rst_n is low.
module rv_multicycle_ctrl (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] op,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       adr_src,
    output logic       ir_write,
    output logic       pc_write,
    output logic       reg_write,
    output logic [1:0] ula_src_a,
    output logic [1:0] ula_src_b,
    output logic [2:0] ula_control,
    output logic [1:0] imm_src,
    output logic [1:0] result_src,
    output logic       instr_done,
    output logic       halted
);
    typedef enum logic [3:0] {
        FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMREAD, MEMWB, MEMWRITE, BEQ, HALT
    } state_t;
    state_t     state_q, state_d;
    logic       halted_q, r_ok;
    logic [2:0] r_ctl;
    always_comb begin
        r_ok  = 1'b1;
        r_ctl = 3'b000;
        case ({funct3, funct7})
            {3'b000, 7'b0000000}: r_ctl = 3'b000;
            {3'b000, 7'b0100000}: r_ctl = 3'b001;
            {3'b111, 7'b0000000}: r_ctl = 3'b010;
            {3'b110, 7'b0000000}: r_ctl = 3'b011;
            {3'b100, 7'b0000000}: r_ctl = 3'b100;
            {3'b010, 7'b0000000}: r_ctl = 3'b101;
            default:              r_ok  = 1'b0;
        endcase
    end
    always_comb begin
        state_d     = state_q;
        mem_req     = 1'b0;
        mem_write   = 1'b0;
        adr_src     = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        reg_write   = 1'b0;
        ula_src_a   = 2'b00;
        ula_src_b   = 2'b00;
        ula_control = 3'b000;
        imm_src     = 2'b00;
        result_src  = 2'b00;
        instr_done  = 1'b0;
        if (rst_n) begin
            case (state_q)
                FETCH: begin
                    mem_req    = 1'b1;
                    ula_src_b  = 2'b10;
                    result_src = 2'b10;
                    ir_write   = mem_ready;
                    pc_write   = mem_ready;
                    state_d    = mem_ready ? DECODE : FETCH;
                end
                DECODE: begin
                    ula_src_a = 2'b01;
                    ula_src_b = 2'b01;
                    imm_src   = 2'b10;
                    state_d   = (op == 7'b0110011 && r_ok) ? EXECR :
                                (op == 7'b0010011 && funct3 == 3'b000) ? EXECI :
                                ((op == 7'b0000011 || op == 7'b0100011) && funct3 == 3'b000) ? MEMADR :
                                (op == 7'b1100011 && funct3 == 3'b000) ? BEQ : HALT;
                end
                EXECR: begin
                    ula_src_a   = 2'b10;
                    ula_control = r_ctl;
                    state_d     = ALUWB;
                end
                EXECI: begin
                    ula_src_a = 2'b10;
                    ula_src_b = 2'b01;
                    state_d   = ALUWB;
                end
                ALUWB: begin
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                MEMADR: begin
                    ula_src_a = 2'b10;
                    ula_src_b = 2'b01;
                    imm_src   = (op == 7'b0100011) ? 2'b01 : 2'b00;
                    state_d   = (op == 7'b0000011) ? MEMREAD : MEMWRITE;
                end
                MEMREAD: begin
                    mem_req = 1'b1;
                    adr_src = 1'b1;
                    state_d = mem_ready ? MEMWB : MEMREAD;
                end
                MEMWB: begin
                    result_src = 2'b01;
                    reg_write  = 1'b1;
                    instr_done = 1'b1;
                    state_d    = FETCH;
                end
                MEMWRITE: begin
                    mem_req    = 1'b1;
                    mem_write  = 1'b1;
                    adr_src    = 1'b1;
                    instr_done = mem_ready;
                    state_d    = mem_ready ? FETCH : MEMWRITE;
                end
                BEQ: begin
                    ula_src_a   = 2'b10;
                    ula_control = 3'b001;
                    pc_write    = zero;
                    instr_done  = 1'b1;
                    state_d     = FETCH;
                end
                default: state_d = HALT;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FETCH;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_q | (state_d == HALT);
        end
    end
    assign halted = halted_q;
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: directed instruction sequences; per-cycle expected output vectors
// are queued as each instruction is issued and compared as the controller steps through it.
module tb_rv_multicycle_ctrl;
    logic       clk = 1'b0, rst_n = 1'b0;
    logic [6:0] op = '0, funct7 = '0;
    logic [2:0] funct3 = '0;
    logic       zero = 1'b0, mem_ready = 1'b0;
    logic       mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, instr_done, halted;
    logic [1:0] ula_src_a, ula_src_b, imm_src, result_src;
    logic [2:0] ula_control;
    logic [18:0] obs;
    int checks = 0, errors = 0;

    typedef struct {logic rdy; logic [18:0] exp; string tag;} step_t;
    step_t sb_q[$];

    always #5 clk = ~clk;

    rv_multicycle_ctrl dut (
        .clk(clk), .rst_n(rst_n), .op(op), .funct3(funct3), .funct7(funct7), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
        .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write), .ula_src_a(ula_src_a),
        .ula_src_b(ula_src_b), .ula_control(ula_control), .imm_src(imm_src),
        .result_src(result_src), .instr_done(instr_done), .halted(halted)
    );

    assign obs = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, ula_src_a,
                  ula_src_b, ula_control, imm_src, result_src, instr_done, halted};

    // mreq,mwr,adr,irw,pcw,rw,src_a,src_b,ctl,imm,res,done,halt
    function automatic logic [18:0] v(input logic mr, mw, ad, iw, pw, rw, input logic [1:0] sa,
                                      sb, input logic [2:0] uc, input logic [1:0] im, rs,
                                      input logic dn, hl);
        return {mr, mw, ad, iw, pw, rw, sa, sb, uc, im, rs, dn, hl};
    endfunction

    function automatic logic [18:0] f_wait();
        return v(1, 0, 0, 0, 0, 0, 2'b00, 2'b10, 3'b000, 2'b00, 2'b10, 0, 0);
    endfunction
    function automatic logic [18:0] f_go();
        return v(1, 0, 0, 1, 1, 0, 2'b00, 2'b10, 3'b000, 2'b00, 2'b10, 0, 0);
    endfunction
    function automatic logic [18:0] dec();
        return v(0, 0, 0, 0, 0, 0, 2'b01, 2'b01, 3'b000, 2'b10, 2'b00, 0, 0);
    endfunction

    task automatic push(input logic rdy, input logic [18:0] exp, input string tag);
        sb_q.push_back('{rdy, exp, tag});
    endtask

    task automatic check(input logic [18:0] exp, input string tag);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive mem_ready, sample 1 time unit later, advance one cycle.
    task automatic drain();
        step_t s;
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            mem_ready = s.rdy;
            #1 check(s.exp, s.tag);
            @(negedge clk);
        end
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7,
                             input logic z);
        op = o; funct3 = f3; funct7 = f7; zero = z;
    endtask

    task automatic rtype(input logic [2:0] f3, input logic [6:0] f7, input logic [2:0] uc,
                         input int fw);
        set_instr(7'b0110011, f3, f7, 1'b0);
        for (int i = 0; i < fw; i++) push(0, f_wait(), "r_fetch_wait");
        push(1, f_go(), "r_fetch");
        push(1, dec(), "r_decode");
        push(1, v(0, 0, 0, 0, 0, 0, 2'b10, 2'b00, uc, 2'b00, 2'b00, 0, 0), "r_execr");
        push(1, v(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1, 0), "r_aluwb");
        drain();
    endtask

    task automatic addi();
        set_instr(7'b0010011, 3'b000, 7'b1010101, 1'b0);
        push(1, f_go(), "i_fetch");
        push(1, dec(), "i_decode");
        push(1, v(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 2'b00, 0, 0), "i_execi");
        push(1, v(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1, 0), "i_aluwb");
        drain();
    endtask

    task automatic lb(input int mw);
        set_instr(7'b0000011, 3'b000, 7'b0000000, 1'b0);
        push(1, f_go(), "lb_fetch");
        push(1, dec(), "lb_decode");
        push(1, v(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b00, 2'b00, 0, 0), "lb_memadr");
        for (int i = 0; i < mw; i++)
            push(0, v(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0, 0), "lb_memread_wait");
        push(1, v(1, 0, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0, 0), "lb_memread");
        push(1, v(0, 0, 0, 0, 0, 1, 2'b00, 2'b00, 3'b000, 2'b00, 2'b01, 1, 0), "lb_memwb");
        drain();
    endtask

    task automatic sb_start(input int mw);
        set_instr(7'b0100011, 3'b000, 7'b0000000, 1'b0);
        push(1, f_go(), "sb_fetch");
        push(1, dec(), "sb_decode");
        push(1, v(0, 0, 0, 0, 0, 0, 2'b10, 2'b01, 3'b000, 2'b01, 2'b00, 0, 0), "sb_memadr");
        for (int i = 0; i < mw; i++)
            push(0, v(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0, 0), "sb_memwrite_wait");
    endtask

    task automatic beq(input logic z);
        set_instr(7'b1100011, 3'b000, 7'b0000000, z);
        push(1, f_go(), "beq_fetch");
        push(1, dec(), "beq_decode");
        push(1, v(0, 0, 0, 0, z, 0, 2'b10, 2'b00, 3'b001, 2'b00, 2'b00, 1, 0), "beq_exec");
        drain();
    endtask

    task automatic illegal(input logic [6:0] o, input logic [2:0] f3, input logic [6:0] f7);
        set_instr(o, f3, f7, 1'b0);
        push(1, f_go(), "ill_fetch");
        push(1, dec(), "ill_decode");
        for (int i = 0; i < 4; i++)
            push(1, v(0, 0, 0, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 0, 1), "ill_halt");
        drain();
    endtask

    task automatic reset_pulse(input string tag);
        rst_n = 1'b0;
        #1 check('0, tag);
        @(negedge clk);
        check('0, tag);
        rst_n = 1'b1;
    endtask

    initial begin
        @(negedge clk);
        @(negedge clk);
        check('0, "reset_outputs");
        rst_n = 1'b1;
        rtype(3'b000, 7'b0000000, 3'b000, 0);
        rtype(3'b000, 7'b0100000, 3'b001, 2);
        rtype(3'b111, 7'b0000000, 3'b010, 0);
        rtype(3'b110, 7'b0000000, 3'b011, 1);
        rtype(3'b100, 7'b0000000, 3'b100, 0);
        rtype(3'b010, 7'b0000000, 3'b101, 0);
        addi();
        lb(0);
        lb(3);
        sb_start(0);
        push(1, v(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1, 0), "sb_memwrite");
        drain();
        sb_start(2);
        push(1, v(1, 1, 1, 0, 0, 0, 2'b00, 2'b00, 3'b000, 2'b00, 2'b00, 1, 0), "sb_memwrite");
        drain();
        beq(1'b1);
        beq(1'b0);
        illegal(7'b1111111, 3'b000, 7'b0000000);
        reset_pulse("halt_reset");
        rtype(3'b000, 7'b0000000, 3'b000, 0);
        illegal(7'b0110011, 3'b000, 7'b1111111);
        reset_pulse("halt_reset_r");
        addi();
        sb_start(2);
        drain();
        reset_pulse("memwrite_abort");
        lb(1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rv_multicycle_ctrl.md
RV_MULTICYCLE_CTRL -- requirements
Module: rv_multicycle_ctrl

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset: clk, rst_n.
REQ-002 Ports SHALL be (name  direction  width  meaning):
 clk  in  1  rising-edge clock
 rst_n  in  1  async active-low reset
 op  in  7  instruction[6:0], from instruction register
 funct3  in  3  instruction[14:12]
 funct7  in  7  instruction[31:25]
 zero  in  1  ULA result == 0
 mem_ready  in  1  memory has completed the current access
 mem_req  out  1  memory access request
 mem_write  out  1  write request (qualifies mem_req)
 adr_src  out  1  address mux: 0 = PC, 1 = result
 ir_write  out  1  load instruction register and old_pc
 pc_write  out  1  load PC from result
 reg_write  out  1  register file write
 ula_src_a  out  2  00 = PC, 01 = old_pc, 10 = rs1
 ula_src_b  out  2  00 = rs2, 01 = imm, 10 = constant 4
 ula_control  out  3  000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt
 imm_src  out  2  00 I, 01 S, 10 B
 result_src  out  2  00 ula_out register, 01 read data, 10 ULA result
 instr_done  out  1  one-cycle pulse on the last cycle of each instruction
 halted  out  1  illegal instruction seen; sticky

Function
REQ-003 States SHALL be FETCH, DECODE, EXECR, EXECI, ALUWB, MEMADR, MEMREAD, MEMWB, MEMWRITE, BEQ, HALT; the state register is the only storage besides halted.
REQ-004 FETCH SHALL drive mem_req=1, adr_src=0, ula_src_a=00, ula_src_b=10, ula_control=000, result_src=10; it holds while mem_ready=0; on mem_ready=1 it pulses ir_write=1 and pc_write=1 and goes to DECODE.
REQ-005 DECODE SHALL drive ula_src_a=01, ula_src_b=01, imm_src=10, ula_control=000 (branch target into ula_out), then route by op:
 0110011 with a legal funct3/funct7 pair -> EXECR; 0010011 with funct3=000 -> EXECI; 0000011 or 0100011 with funct3=000 -> MEMADR; 1100011 with funct3=000 -> BEQ; any other -> HALT.
REQ-006 Legal R-type pairs (funct3/funct7) SHALL be 000/0000000 add, 000/0100000 sub, 111/0000000 and, 110/0000000 or, 100/0000000 xor, 010/0000000 slt, mapped to the ula_control codes of REQ-002.
REQ-007 EXECR SHALL drive ula_src_a=10, ula_src_b=00 and the decoded ula_control, then go to ALUWB.
REQ-008 EXECI SHALL drive ula_src_a=10, ula_src_b=01, imm_src=00, ula_control=000, then go to ALUWB.
REQ-009 ALUWB SHALL drive result_src=00, reg_write=1, instr_done=1, then go to FETCH.
REQ-010 MEMADR SHALL drive ula_src_a=10, ula_src_b=01, ula_control=000, imm_src=00 for op 0000011 or 01 for op 0100011, then go to MEMREAD (load) or MEMWRITE (store).
REQ-011 MEMREAD SHALL drive mem_req=1, adr_src=1, result_src=00, and hold until mem_ready=1, then go to MEMWB.
REQ-012 MEMWB SHALL drive result_src=01, reg_write=1, instr_done=1, then go to FETCH.
REQ-013 MEMWRITE SHALL drive mem_req=1, mem_write=1, adr_src=1, result_src=00, and hold until mem_ready=1; on that cycle it asserts instr_done=1, then goes to FETCH.
REQ-014 BEQ SHALL drive ula_src_a=10, ula_src_b=00, ula_control=001, result_src=00, pc_write=zero, instr_done=1, then go to FETCH.
REQ-015 HALT SHALL set halted=1, keep every other output 0, and remain in HALT until reset.
REQ-016 In every state, outputs not listed SHALL be 0; mem_req, reg_write, pc_write and ir_write SHALL never be X.
REQ-017 With mem_ready=1 on every cycle, latency SHALL be: R-type and addi 4 cycles, lb 5, sb 4, beq 3. Each cycle of mem_ready=0 in FETCH, MEMREAD or MEMWRITE adds 1 cycle.
REQ-018 While a memory wait is in progress, the request outputs SHALL stay stable and no write-enable SHALL pulse.

Reset
REQ-019 While rst_n=0 the state SHALL be FETCH, halted SHALL be 0 and all outputs SHALL be 0; the first mem_req SHALL occur in the first clk edge-cycle after rst_n rises.
REQ-020 Asserting reset mid-instruction (including during a memory wait) SHALL abort the instruction immediately, with no further reg_write, pc_write or mem_write.

Verification
REQ-021 add (op 0110011, f3 000, f7 0000000), mem_ready=1 -> FETCH, DECODE, EXECR, ALUWB; ula_control=000 in EXECR; reg_write and instr_done high only in cycle 4.
REQ-022 lb, with mem_ready held 0 for 3 cycles in MEMREAD -> total latency 8 cycles; mem_req/adr_src=1 stable throughout; reg_write=1 with result_src=01 only in MEMWB.
REQ-023 beq with zero=1 -> pc_write=1 in the BEQ cycle; beq with zero=0 -> pc_write=0; both give instr_done=1 in cycle 3.
REQ-024 sb -> imm_src=01 in MEMADR; mem_write=1 only in MEMWRITE; reg_write never asserted.
REQ-025 op 1111111, or R-type f3 000 with f7 1111111 -> HALT after DECODE with halted=1; further fetches blocked until rst_n pulse; then FETCH resumes with halted=0.
REQ-026 rst_n dropped during a MEMWRITE wait -> mem_req and mem_write go to 0 asynchronously; after release the block restarts at FETCH.
